emulib_ready_valid_rr_arb: RTL
==============================

Name: emulib_ready_valid_rr_arb

Overview:
- Registered N-to-1 ready/valid arbiter with round-robin fairness, parametrised in source count and data width.
- Used wherever several emulation-side producers share one downstream channel, e.g. merging trace or DMA request streams.
- Replaces fixed-priority combinational merging with a fair, timing-isolated merge through one output register stage.
- Optionally holds a grant for a whole multi-beat packet.

Parameters:
- NUM_S, 2: number of source channels (>=1).
- DATA_WIDTH, 32: payload width per channel (>=1).
- SEL_WIDTH, $clog2(NUM_S) with minimum 1: width of the internal round-robin pointer (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- s_valid  input  NUM_S  per-source valid.
- s_ready  output  NUM_S  per-source ready; one-hot or zero.
- s_data  input  DATA_WIDTH*NUM_S  source i payload at [i*DATA_WIDTH +: DATA_WIDTH].
- m_valid  output  1  output beat valid (registered).
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  output payload (registered).
- m_sel  output  NUM_S  one-hot index of the source of the current output beat (registered).

Behaviour:
- Reset: m_valid=0, m_data=0, m_sel=0, rr pointer=0, lock=0. s_ready=0 during the reset cycle.
- Output stage:
  - Single register slice.
  - load_en = !m_valid | m_ready.
  - s_ready[i] = load_en & grant[i] & !rst.
- Arbitration (combinational, each cycle): grant = first set s_valid bit scanning from index ptr upward, wrapping to 0 through ptr-1. grant=0 when no s_valid.
- Transfer:
  - Source i handshakes when s_valid[i] & s_ready[i].
  - On that edge: m_data<=s_data slice i, m_sel<=onehot(i), m_valid<=1, ptr<=(i+1) mod NUM_S.
- Drain: if m_valid & m_ready and no source handshakes, then m_valid<=0. m_data and m_sel hold their last value.
- Stall: while m_valid & !m_ready, m_valid, m_data and m_sel are stable and all s_ready=0.
- Latency: 1 cycle from source handshake to m_valid. Throughput is 1 beat/cycle when m_ready is held high (simultaneous drain and load).
- Fairness: with all NUM_S sources continuously valid and m_ready=1, grants rotate 0,1,...,NUM_S-1,0,... No source waits more than NUM_S-1 grants.
- Pointer wrap: ptr after granting index NUM_S-1 is 0. NUM_S=1 degenerates to a pipeline register with ptr fixed at 0.
- Ready-valid rules:
  - s_valid may deassert before its handshake without loss or duplication; the grant simply moves.
  - s_valid has no combinational dependency on s_ready.
  - s_ready depends combinationally on m_ready, m_valid and s_valid.
- Reset mid-operation: a pending m_valid beat is discarded, the pointer returns to 0 and lock clears.

Optional Feature:
- Macro EMULIB_RV_ARB_PKT_LOCK_EN.
- When defined, two ports are added:
  - s_last input NUM_S.
  - m_last output 1: registered with m_data, reset 0.
- Lock behaviour: after a handshake from source i with s_last[i]=0, lock<=1 and the locked index is held. While locked, grant = s_valid[locked] ? onehot(locked) : 0, and other sources are never granted. A handshake with s_last=1 clears lock and advances ptr to locked+1. ptr does not advance on non-last beats.
- When undefined: no s_last/m_last ports; every beat is arbitrated independently, as above.

Test Plan:
- Reset then idle: assert rst 2 cycles with s_valid=2'b11 -> m_valid=0, s_ready=0, m_sel=0. First cycle after release: s_ready=2'b01.
- Round-robin, NUM_S=3, all valid, m_ready=1, s_data={3,2,1} per source -> m_sel sequence 001,010,100,001 and m_data sequence 1,2,3,1. One beat per cycle, no gaps.
- Backpressure: single beat 0xA5 from source 1, m_ready=0 for 4 cycles -> m_valid=1, m_data=0xA5, m_sel=010 stable, s_ready=0 throughout. Release m_ready -> beat accepted exactly once.
- Withdrawn request: source 0 raises s_valid during a stall, drops it before m_ready returns, while source 2 stays valid -> source 2 granted next; source 0 data never appears.
- Reset mid-stream: rst asserted while m_valid=1 with ptr=2 -> next cycle m_valid=0. After release, with all sources valid, first grant is source 0.
- Packet lock (macro defined, NUM_S=2): source 0 sends a 3-beat packet with s_last=0,0,1 while source 1 is continuously valid -> m_sel=01 for 3 beats, m_last=0,0,1, then m_sel=10.

Source files
------------

// File: rtl/emulib_ready_valid_rr_arb_if.sv
// Handshake bundle for emulib_ready_valid_rr_arb: NUM_S source channels merged onto one output channel.
// s_last/m_last exist only when EMULIB_RV_ARB_PKT_LOCK_EN is defined.
interface emulib_ready_valid_rr_arb_if #(
    parameter int NUM_S      = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_S-1:0]            s_valid;
    logic [NUM_S-1:0]            s_ready;
    logic [DATA_WIDTH*NUM_S-1:0] s_data;
    logic                        m_valid;
    logic                        m_ready;
    logic [DATA_WIDTH-1:0]       m_data;
    logic [NUM_S-1:0]            m_sel;
`ifdef EMULIB_RV_ARB_PKT_LOCK_EN
    logic [NUM_S-1:0]            s_last;
    logic                        m_last;

    modport master (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_sel, m_last
    );
    modport slave (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_sel, m_last
    );
`else
    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sel
    );
    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sel
    );
`endif
endinterface

// File: rtl/emulib_ready_valid_rr_arb.sv
// Round-robin N:1 ready/valid merge into one registered output slice; EMULIB_RV_ARB_PKT_LOCK_EN holds grant per packet.
// Latency: 1 cycle from source handshake to m_valid; 1 beat/cycle while m_ready stays high.
// Backpressure: s_ready is driven only when the slice is empty or draining this cycle; a stalled beat holds all s_ready low.
module emulib_ready_valid_rr_arb #(
    parameter  int NUM_S      = 2,
    parameter  int DATA_WIDTH = 32,
    localparam int SEL_WIDTH  = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    emulib_ready_valid_rr_arb_if.master   bus
);

    logic [NUM_S-1:0]      hi_mask;
    logic [NUM_S-1:0]      hi_req;
    logic [NUM_S-1:0]      pick_req;
    logic [SEL_WIDTH-1:0]  rr_idx;
    logic [SEL_WIDTH-1:0]  gnt_idx;
    logic                  gnt_any;
    logic [NUM_S-1:0]      grant;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [SEL_WIDTH-1:0]  nxt_idx;
    logic                  load_en;
    logic                  hs;

    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [NUM_S-1:0]      m_sel_q;

`ifdef EMULIB_RV_ARB_PKT_LOCK_EN
    typedef enum logic {ST_ARB, ST_LOCK} lock_state_t;
    lock_state_t           state_q, state_d;
    logic [SEL_WIDTH-1:0]  lock_idx_q, lock_idx_d;
    logic                  m_last_q;
`endif

    // Requests at or above the pointer win first; otherwise wrap to the lowest requester.
    always_comb begin
        hi_mask  = '0;
        rr_idx   = '0;
        for (int i = 0; i < NUM_S; i++) begin
            hi_mask[i] = (SEL_WIDTH'(i) >= ptr_q);
        end
        hi_req   = bus.s_valid & hi_mask;
        pick_req = (|hi_req) ? hi_req : bus.s_valid;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (pick_req[i]) begin
                rr_idx = SEL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        gnt_idx = rr_idx;
        gnt_any = |bus.s_valid;
`ifdef EMULIB_RV_ARB_PKT_LOCK_EN
        if (state_q == ST_LOCK) begin
            gnt_idx = lock_idx_q;
            gnt_any = bus.s_valid[lock_idx_q];
        end
`endif
        grant = gnt_any ? (NUM_S'(1) << gnt_idx) : '0;
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (grant[i]) begin
                gnt_data = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign load_en     = !m_valid_q || bus.m_ready;
    assign bus.s_ready = (load_en && !rst) ? grant : '0;
    assign hs          = gnt_any && load_en && !rst;
    assign nxt_idx     = (gnt_idx == SEL_WIDTH'(NUM_S - 1)) ? '0 : gnt_idx + SEL_WIDTH'(1);

`ifdef EMULIB_RV_ARB_PKT_LOCK_EN
    // The pointer only moves past a source once its packet has ended.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        if (hs) begin
            if (bus.s_last[gnt_idx]) begin
                state_d = ST_ARB;
                ptr_d   = nxt_idx;
            end else begin
                state_d    = ST_LOCK;
                lock_idx_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            lock_idx_q <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            if (hs) begin
                m_last_q <= bus.s_last[gnt_idx];
            end
        end
    end

    assign bus.m_last = m_last_q;
`else
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = nxt_idx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sel_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (hs) begin
                m_valid_q <= 1'b1;
                m_data_q  <= gnt_data;
                m_sel_q   <= grant;
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_sel   = m_sel_q;

endmodule
